// File: rtl/level_fifo.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// fill-level reporting, almost-full/almost-empty thresholds and sticky error flags.
module level_fifo #(
  parameter int unsigned nrOfEntries      = 16,
  parameter int unsigned bitWidth         = 32,
  parameter int unsigned almostFullLevel  = 12,
  parameter int unsigned almostEmptyLevel = 4,
  parameter int unsigned fallThrough      = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             clearErrors,
  input  logic [bitWidth-1:0]              pushData,
  output logic [bitWidth-1:0]              popData,
  output logic                             full,
  output logic                             empty,
  output logic                             almostFull,
  output logic                             almostEmpty,
  output logic [$clog2(nrOfEntries):0]     fillLevel,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int unsigned ptrWidth = $clog2(nrOfEntries);
  localparam int unsigned cntWidth = ptrWidth + 1;

  logic [bitWidth-1:0] mem [nrOfEntries];
  logic [ptrWidth-1:0] wrPtr;
  logic [ptrWidth-1:0] rdPtr;
  logic [cntWidth-1:0] count;
  logic                isFull;
  logic                isEmpty;
  logic                pushOK;
  logic                popOK;

  // Status is decoded from the registered count only, never from push/pop.
  assign isFull      = (count == cntWidth'(nrOfEntries));
  assign isEmpty     = (count == '0);
  assign full        = isFull;
  assign empty       = isEmpty;
  assign almostFull  = (count >= cntWidth'(almostFullLevel));
  assign almostEmpty = (count <= cntWidth'(almostEmptyLevel));
  assign fillLevel   = count;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign pushOK = push & (~isFull | pop);
  assign popOK  = pop & ~isEmpty;

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (pushOK) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOK) begin
        wrPtr <= wrPtr + ptrWidth'(1);
      end
      if (popOK) begin
        rdPtr <= rdPtr + ptrWidth'(1);
      end
      case ({pushOK, popOK})
        2'b10:   count <= count + cntWidth'(1);
        2'b01:   count <= count - cntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~pushOK) begin
        overflow <= 1'b1;
      end else if (clearErrors) begin
        overflow <= 1'b0;
      end
      if (pop & ~popOK) begin
        underflow <= 1'b1;
      end else if (clearErrors) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (fallThrough != 0) begin : g_fwft
      assign popData = isEmpty ? '0 : mem[rdPtr];
    end else begin : g_registered
      logic [bitWidth-1:0] popReg;
      always_ff @(posedge clock) begin
        if (reset) begin
          popReg <= '0;
        end else if (popOK) begin
          popReg <= mem[rdPtr];
        end
      end
      assign popData = popReg;
    end
  endgenerate

endmodule

// File: tb/tb_level_fifo.sv
// Directed self-checking bench for level_fifo: registered-read instance and FWFT instance.
module tb_level_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        pushA, popA, clrA;
  logic [31:0] dinA, doutA;
  logic        fullA, emptyA, afA, aeA, ovfA, unfA;
  logic [4:0]  lvlA;
  logic        pushB, popB, clrB;
  logic [31:0] dinB, doutB;
  logic        fullB, emptyB, afB, aeB, ovfB, unfB;
  logic [4:0]  lvlB;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clock = ~clock;

  level_fifo #(.fallThrough(0)) dutA (
    .clock(clock), .reset(reset), .push(pushA), .pop(popA), .clearErrors(clrA),
    .pushData(dinA), .popData(doutA), .full(fullA), .empty(emptyA),
    .almostFull(afA), .almostEmpty(aeA), .fillLevel(lvlA),
    .overflow(ovfA), .underflow(unfA)
  );

  level_fifo #(.fallThrough(1)) dutB (
    .clock(clock), .reset(reset), .push(pushB), .pop(popB), .clearErrors(clrB),
    .pushData(dinB), .popData(doutB), .full(fullB), .empty(emptyB),
    .almostFull(afB), .almostEmpty(aeB), .fillLevel(lvlB),
    .overflow(ovfB), .underflow(unfB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pushA = 0; popA = 0; clrA = 0; dinA = '0;
    pushB = 0; popB = 0; clrB = 0; dinB = '0;
    step(); step();
    reset = 1'b0;

    chk("rst_empty", 32'(emptyA), 1);
    chk("rst_full", 32'(fullA), 0);
    chk("rst_ae", 32'(aeA), 1);
    chk("rst_af", 32'(afA), 0);
    chk("rst_level", 32'(lvlA), 0);
    chk("rst_data", doutA, 0);
    chk("rst_ovf", 32'(ovfA), 0);
    chk("rst_unf", 32'(unfA), 0);
    chk("rst_fwft_data", doutB, 0);
    chk("rst_fwft_empty", 32'(emptyB), 1);

    // Fill with 0..15.
    pushA = 1;
    for (int i = 0; i < 16; i++) begin
      dinA = 32'(i);
      step();
      chk("fill_level", 32'(lvlA), 32'(i + 1));
      chk("fill_af", 32'(afA), (i + 1 >= 12) ? 1 : 0);
      chk("fill_ae", 32'(aeA), (i + 1 <= 4) ? 1 : 0);
      chk("fill_full", 32'(fullA), (i == 15) ? 1 : 0);
    end
    dinA = 32'h99;
    step();
    chk("ovf_set", 32'(ovfA), 1);
    chk("ovf_level", 32'(lvlA), 16);
    chk("ovf_data_hold", doutA, 0);
    pushA = 0;

    // Drain: data 0..15, the rejected 0x99 must never appear.
    popA = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_data", doutA, 32'(i));
      chk("drain_level", 32'(lvlA), 32'(15 - i));
      chk("drain_empty", 32'(emptyA), (i == 15) ? 1 : 0);
    end
    step();
    chk("unf_set", 32'(unfA), 1);
    chk("unf_data_hold", doutA, 32'hF);
    chk("unf_ovf_sticky", 32'(ovfA), 1);
    popA = 0;
    clrA = 1;
    step();
    clrA = 0;
    chk("clr_ovf", 32'(ovfA), 0);
    chk("clr_unf", 32'(unfA), 0);

    // Advance pointers by 10 so the next 16 words wrap.
    pushA = 1;
    for (int i = 0; i < 10; i++) begin
      dinA = 32'h200 + 32'(i);
      step();
    end
    pushA = 0;
    popA = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pre_wrap_data", doutA, 32'h200 + 32'(i));
    end
    popA = 0;
    pushA = 1;
    for (int i = 0; i < 16; i++) begin
      dinA = 32'h100 + 32'(i);
      step();
    end
    chk("wrap_full", 32'(fullA), 1);

    // Push+pop while full: level holds, no overflow.
    dinA = 32'h300;
    popA = 1;
    step();
    chk("pp_full_level", 32'(lvlA), 16);
    chk("pp_full_ovf", 32'(ovfA), 0);
    chk("pp_full_data", doutA, 32'h100);
    pushA = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("wrap_data", doutA, (i < 15) ? 32'h101 + 32'(i) : 32'h300);
    end
    popA = 0;
    chk("wrap_empty", 32'(emptyA), 1);

    // Push+pop while empty: push taken, pop rejected.
    pushA = 1; popA = 1; dinA = 32'h55;
    step();
    pushA = 0; popA = 0;
    chk("pp_empty_level", 32'(lvlA), 1);
    chk("pp_empty_unf", 32'(unfA), 1);
    chk("pp_empty_data_hold", doutA, 32'h300);

    // Error set in same cycle as clear wins.
    popA = 1; clrA = 1;
    step();
    step();
    popA = 0; clrA = 0;
    chk("pp_empty_pop", doutA, 32'h55);
    chk("set_beats_clr", 32'(unfA), 1);

    // Mid-stream reset at level 7 together with a push.
    pushA = 1;
    for (int i = 0; i < 7; i++) begin
      dinA = 32'h400 + 32'(i);
      step();
    end
    chk("mid_level", 32'(lvlA), 7);
    reset = 1;
    step();
    reset = 0;
    pushA = 0;
    chk("mid_rst_level", 32'(lvlA), 0);
    chk("mid_rst_empty", 32'(emptyA), 1);
    chk("mid_rst_data", doutA, 0);
    chk("mid_rst_unf", 32'(unfA), 0);
    chk("mid_rst_ovf", 32'(ovfA), 0);

    // FWFT: pushed word is visible the cycle after the push, no pop needed.
    pushB = 1; dinB = 32'hA5;
    step();
    pushB = 0;
    chk("fwft_show", doutB, 32'hA5);
    chk("fwft_level", 32'(lvlB), 1);
    step();
    chk("fwft_hold", doutB, 32'hA5);
    popB = 1;
    step();
    popB = 0;
    chk("fwft_pop_data", doutB, 0);
    chk("fwft_pop_empty", 32'(emptyB), 1);
    pushB = 1; dinB = 32'h11;
    step();
    dinB = 32'h22;
    step();
    pushB = 0;
    chk("fwft_head", doutB, 32'h11);
    popB = 1;
    step();
    popB = 0;
    chk("fwft_next", doutB, 32'h22);
    chk("fwft_next_level", 32'(lvlB), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/level_fifo.md
# level_fifo

Parametrised synchronous single-clock FIFO: the next-generation buffer for the pipeline's inter-stage data paths. It replaces the fixed 16×32 FIFO with configurable depth and width, a selectable read mode (registered or first-word-fall-through), fill-level reporting, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between producer and consumer stages that both run on `clock`.

## Interface

Parameters:
- `nrOfEntries`, 16: depth. Must be a power of two and ≥2.
- `bitWidth`, 32: data width.
- `almostFullLevel`, 12: `almostFull` asserts when count ≥ this value. Legal range 1..nrOfEntries.
- `almostEmptyLevel`, 4: `almostEmpty` asserts when count ≤ this value. Legal range 0..nrOfEntries-1.
- `fallThrough`, 0: 0 selects registered read; 1 selects first-word-fall-through (FWFT).

Ports:
- `clock`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `clearErrors`  in  1  clears the sticky `overflow`/`underflow` flags.
- `pushData`  in  bitWidth  write data.
- `popData`  out  bitWidth  read data.
- `full`  out  1  count == nrOfEntries.
- `empty`  out  1  count == 0.
- `almostFull`  out  1  count ≥ almostFullLevel.
- `almostEmpty`  out  1  count ≤ almostEmptyLevel.
- `fillLevel`  out  clog2(nrOfEntries)+1  current count.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation

- Storage: nrOfEntries×bitWidth register array. Write and read pointers are clog2(nrOfEntries) bits wide and wrap naturally from nrOfEntries-1 to 0. The count register is clog2(nrOfEntries)+1 bits wide.
- Push acceptance: `pushOK = push & (!full | pop)`. A push while full is accepted only together with an accepted pop. On `pushOK`: `mem[wrPtr] <= pushData`, then `wrPtr+1`.
- Pop acceptance: `popOK = pop & !empty`. A pop while empty is always rejected, even with a simultaneous push.
- On `popOK`: `rdPtr+1`.
- Count update: +1 on pushOK only, −1 on popOK only, unchanged when both or neither.
- Status outputs: `full`, `empty`, `almostFull`, `almostEmpty` and `fillLevel` are decoded from the registered count only. They never depend combinationally on `push` or `pop`.
- Error flags:
  - `overflow` sets on `push & !pushOK`.
  - `underflow` sets on `pop & !popOK`.
  - `clearErrors` clears both flags. A set in the same cycle as `clearErrors` wins.
  - A rejected operation changes no other state.
- Read mode `fallThrough=0`: on `popOK`, `popData <= mem[rdPtr]`. Otherwise `popData` holds its value.
- Read mode `fallThrough=1`: `popData = empty ? 0 : mem[rdPtr]`, combinational from registered state. `pop` acknowledges the displayed word.
- Reset: pointers, count, `overflow`, `underflow` and registered `popData` all go to 0. Memory contents are not cleared.
  - Post-reset outputs: `empty=1`, `full=0`, `almostEmpty=1`, `almostFull=0`, `fillLevel=0`, `popData=0`.
  - Reset takes priority over push, pop and clearErrors in the same cycle, and is valid mid-operation.

## Timing

- Push accepted at edge N: the word is counted and flags update after edge N.
- FWFT mode, push into an empty FIFO at edge N: the word appears on `popData` in cycle N+1.
- Registered mode, pop accepted at edge N: `popData` shows the head word after edge N and holds it until the next accepted pop.
- Full throughput: one push and one pop per cycle, sustained, at any fill level including full (push+pop) and empty (push only).
- No combinational path from `push`/`pop` to any output.

## Test plan

- Reset, then 16 pushes of values 0x0..0xF with no pops → `full=1`, `fillLevel=16`, `almostFull` first seen after the 12th push; a 17th push sets `overflow=1` and contents are unchanged.
- From full, 16 pops (registered mode) → `popData` sequence 0x0..0xF, `empty=1` after the last pop; a 17th pop sets `underflow`; then `clearErrors` → both flags 0.
- Wrap-around: 10 pushes, 10 pops, then 16 pushes of 0x100+i and 16 pops → data returned in order 0x100..0x10F across the pointer wrap.
- Simultaneous events:
  - push+pop when full → `fillLevel` stays 16, no `overflow`.
  - push+pop when empty → `fillLevel=1`, `underflow=1`.
- FWFT (`fallThrough=1`): push 0xA5 into empty at edge N → `popData=0xA5` in cycle N+1 with no pop; pop → `popData=0`, `empty=1`.
- Reset asserted mid-stream at `fillLevel=7` together with push → next cycle: `fillLevel=0`, `empty=1`, `popData=0`, error flags 0.
